// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and its load extender.
package wb_pkg;

   localparam int XLEN_DEF      = 32;
   localparam int NREG_BITS_DEF = 5;

   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_ALU  = 2'd1,
      WB_PC4  = 2'd2,
      WB_LOAD = 2'd3
   } wb_src_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic {
      S_IDLE     = 1'b0,
      S_WAIT_MEM = 1'b1
   } wb_state_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Retire/memory-response/register-file bundle of the writeback stage.
// master = upstream pipeline + data memory side, slave = writeback_unit.
interface writeback_unit_if #(
   parameter int XLEN      = 32,
   parameter int NREG_BITS = 5
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [NREG_BITS-1:0] in_rd;
   logic [1:0]           in_src;
   logic [XLEN-1:0]      in_alu_result;
   logic [XLEN-1:0]      in_pc;
   logic [2:0]           in_funct3;
   logic                 mem_rvalid;
   logic [XLEN-1:0]      mem_rdata;
   logic                 wr_ena;
   logic [NREG_BITS-1:0] wr_addr;
   logic [XLEN-1:0]      wr_data;
   logic                 pending_valid;
   logic [NREG_BITS-1:0] pending_rd;
   logic                 err;

   modport master (
      output in_valid, in_rd, in_src, in_alu_result, in_pc, in_funct3,
             mem_rvalid, mem_rdata,
      input  in_ready, wr_ena, wr_addr, wr_data, pending_valid, pending_rd, err
   );

   modport slave (
      input  in_valid, in_rd, in_src, in_alu_result, in_pc, in_funct3,
             mem_rvalid, mem_rdata,
      output in_ready, wr_ena, wr_addr, wr_data, pending_valid, pending_rd, err
   );
endinterface

// File: rtl/writeback_unit_load_extender.sv
// RV32I load lane select + sign/zero extension, plus alignment/legality flags.
// Purely combinational so it can be shared with the store/load path.
module load_extender
   import wb_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      addr_lsb_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [XLEN-1:0] data_o,
   output logic            misaligned_o,
   output logic            illegal_o
);

   logic [XLEN-1:0] byte_sh;
   logic [XLEN-1:0] half_sh;
   logic [7:0]      byte_v;
   logic [15:0]     half_v;

   assign byte_sh = rdata_i >> {addr_lsb_i, 3'b000};
   assign half_sh = rdata_i >> {addr_lsb_i[1], 4'b0000};
   assign byte_v  = byte_sh[7:0];
   assign half_v  = half_sh[15:0];

   always_comb begin
      data_o       = '0;
      misaligned_o = 1'b0;
      illegal_o    = 1'b0;
      case (funct3_i)
         F3_LB:  data_o = {{(XLEN-8){byte_v[7]}}, byte_v};
         F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_v};
         F3_LH: begin
            data_o       = {{(XLEN-16){half_v[15]}}, half_v};
            misaligned_o = addr_lsb_i[0];
         end
         F3_LHU: begin
            data_o       = {{(XLEN-16){1'b0}}, half_v};
            misaligned_o = addr_lsb_i[0];
         end
         F3_LW: begin
            data_o       = rdata_i;
            misaligned_o = |addr_lsb_i;
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: selects ALU/PC+4/load data and drives the register-file write port.
// Optional WB_INSTRET_EN adds a 64-bit retired-instruction counter output.
module writeback_unit
   import wb_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NREG_BITS = 5
) (
   input  logic            clk,
   input  logic            rst,
   writeback_unit_if.slave wb
`ifdef WB_INSTRET_EN
   ,
   output logic [63:0]     instret
`endif
);

   wb_state_t            state_q;
   logic [NREG_BITS-1:0] rd_q;
   logic [2:0]           f3_q;
   logic [1:0]           lsb_q;
   logic                 wr_ena_q;
   logic [NREG_BITS-1:0] wr_addr_q;
   logic [XLEN-1:0]      wr_data_q;
   logic                 err_q;

   wb_src_t         src;
   logic            waiting;
   logic [XLEN-1:0] src_data_d;
   logic [2:0]      ext_f3;
   logic [1:0]      ext_lsb;
   logic [XLEN-1:0] ext_data;
   logic            ld_mis;
   logic            ld_ill;

   assign src     = wb_src_t'(wb.in_src);
   assign waiting = (state_q == S_WAIT_MEM);

   // One extender serves both paths: in IDLE it vets the incoming load,
   // in WAIT_MEM it formats the response using the latched type/offset.
   assign ext_f3  = waiting ? f3_q  : wb.in_funct3;
   assign ext_lsb = waiting ? lsb_q : wb.in_alu_result[1:0];

   load_extender #(.XLEN(XLEN)) u_ext (
      .funct3_i     (ext_f3),
      .addr_lsb_i   (ext_lsb),
      .rdata_i      (wb.mem_rdata),
      .data_o       (ext_data),
      .misaligned_o (ld_mis),
      .illegal_o    (ld_ill)
   );

   always_comb begin
      src_data_d = wb.in_alu_result;
      if (src == WB_PC4) src_data_d = wb.in_pc + XLEN'(4);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         rd_q      <= '0;
         f3_q      <= '0;
         lsb_q     <= '0;
         wr_ena_q  <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         wr_ena_q <= 1'b0;
         err_q    <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (wb.in_valid) begin
                  if (src == WB_LOAD) begin
                     if (ld_mis || ld_ill) begin
                        err_q <= 1'b1;
                     end else begin
                        rd_q    <= wb.in_rd;
                        f3_q    <= wb.in_funct3;
                        lsb_q   <= wb.in_alu_result[1:0];
                        state_q <= S_WAIT_MEM;
                     end
                  end else if (src != WB_NONE && wb.in_rd != '0) begin
                     wr_ena_q  <= 1'b1;
                     wr_addr_q <= wb.in_rd;
                     wr_data_q <= src_data_d;
                  end
               end
            end
            S_WAIT_MEM: begin
               if (wb.mem_rvalid) begin
                  if (rd_q != '0) begin
                     wr_ena_q  <= 1'b1;
                     wr_addr_q <= rd_q;
                     wr_data_q <= ext_data;
                  end
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wb.in_ready      = ~waiting;
   assign wb.wr_ena        = wr_ena_q;
   assign wb.wr_addr       = wr_addr_q;
   assign wb.wr_data       = wr_data_q;
   assign wb.err           = err_q;
   assign wb.pending_valid = waiting;
   assign wb.pending_rd    = waiting ? rd_q : '0;

`ifdef WB_INSTRET_EN
   logic [63:0] instret_q;
   logic        complete;

   // Rejected (error) loads never reach the load branch of completion.
   assign complete = (!waiting && wb.in_valid && src != WB_LOAD) ||
                     (waiting && wb.mem_rvalid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           instret_q <= '0;
      else if (complete) instret_q <= instret_q + 64'd1;
   end

   assign instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: expected register writes go into a
// scoreboard queue when stimulus is driven and are popped when wr_ena fires.
module tb_writeback_unit;
   import wb_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t sb[$];

   writeback_unit_if #(.XLEN(32), .NREG_BITS(5)) ifc ();

`ifdef WB_INSTRET_EN
   logic [63:0] instret;
   writeback_unit #(.XLEN(32), .NREG_BITS(5)) dut (
      .clk(clk), .rst(rst), .wb(ifc), .instret(instret));
`else
   writeback_unit #(.XLEN(32), .NREG_BITS(5)) dut (
      .clk(clk), .rst(rst), .wb(ifc));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every write seen must match the oldest expected one.
   task automatic monitor();
      wr_t e;
      if (ifc.wr_ena !== 1'b0) begin
         if (sb.size() == 0) begin
            chk("unexpected_write", {63'd0, ifc.wr_ena}, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("wr_addr", {59'd0, ifc.wr_addr}, {59'd0, e.addr});
            chk("wr_data", {32'd0, ifc.wr_data}, {32'd0, e.data});
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      monitor();
   endtask

   task automatic send(input logic [4:0] rd, input logic [1:0] src,
                       input logic [31:0] alu, input logic [31:0] pc,
                       input logic [2:0] f3);
      wr_t e;
      ifc.in_valid      = 1'b1;
      ifc.in_rd         = rd;
      ifc.in_src        = src;
      ifc.in_alu_result = alu;
      ifc.in_pc         = pc;
      ifc.in_funct3     = f3;
      if (rd != 5'd0 && (src == WB_ALU || src == WB_PC4)) begin
         e.addr = rd;
         e.data = (src == WB_ALU) ? alu : pc + 32'd4;
         sb.push_back(e);
      end
      tick();
      ifc.in_valid = 1'b0;
   endtask

   // Issue a load, wait the given cycles, then return rdata.
   task automatic do_load(input logic [4:0] rd, input logic [2:0] f3,
                          input logic [1:0] lsb, input logic [31:0] rdata,
                          input logic [31:0] exp, input int waits);
      wr_t e;
      send(rd, WB_LOAD, {30'h400, lsb}, 32'h0, f3);
      for (int i = 0; i < waits; i++) begin
         chk("wait_ready", {63'd0, ifc.in_ready}, 64'd0);
         chk("wait_pend", {63'd0, ifc.pending_valid}, 64'd1);
         chk("wait_pend_rd", {59'd0, ifc.pending_rd}, {59'd0, rd});
         tick();
      end
      if (rd != 5'd0) begin
         e.addr = rd;
         e.data = exp;
         sb.push_back(e);
      end
      ifc.mem_rvalid = 1'b1;
      ifc.mem_rdata  = rdata;
      tick();
      ifc.mem_rvalid = 1'b0;
      chk("load_done_ready", {63'd0, ifc.in_ready}, 64'd1);
      chk("sb_drained", 64'(sb.size()), 64'd0);
   endtask

   task automatic bad_load(input logic [2:0] f3, input logic [1:0] lsb);
      send(5'd7, WB_LOAD, {30'h400, lsb}, 32'h0, f3);
      chk("err_pulse", {63'd0, ifc.err}, 64'd1);
      chk("err_ready", {63'd0, ifc.in_ready}, 64'd1);
      chk("err_no_pend", {63'd0, ifc.pending_valid}, 64'd0);
      tick();
      chk("err_clear", {63'd0, ifc.err}, 64'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      ifc.in_valid = 1'b0;
      ifc.in_rd = '0;
      ifc.in_src = '0;
      ifc.in_alu_result = '0;
      ifc.in_pc = '0;
      ifc.in_funct3 = '0;
      ifc.mem_rvalid = 1'b0;
      ifc.mem_rdata = '0;

      #12;
      chk("rst_wr_ena", {63'd0, ifc.wr_ena}, 64'd0);
      chk("rst_wr_addr", {59'd0, ifc.wr_addr}, 64'd0);
      chk("rst_wr_data", {32'd0, ifc.wr_data}, 64'd0);
      chk("rst_pend", {63'd0, ifc.pending_valid}, 64'd0);
      chk("rst_pend_rd", {59'd0, ifc.pending_rd}, 64'd0);
      chk("rst_err", {63'd0, ifc.err}, 64'd0);
      #10 rst = 1'b0;
      tick();
      chk("rst_ready", {63'd0, ifc.in_ready}, 64'd1);

      send(5'd5, WB_ALU, 32'hDEADBEEF, 32'h0, 3'b0);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      tick();
      chk("ena_pulse", {63'd0, ifc.wr_ena}, 64'd0);
      chk("addr_hold", {59'd0, ifc.wr_addr}, 64'd5);
      chk("data_hold", {32'd0, ifc.wr_data}, 64'hDEADBEEF);

      send(5'd1, WB_PC4, 32'h0, 32'hFFFFFFFC, 3'b0);
      send(5'd0, WB_ALU, 32'h12345678, 32'h0, 3'b0);
      chk("x0_no_write", {63'd0, ifc.wr_ena}, 64'd0);
      send(5'd3, WB_NONE, 32'h55555555, 32'h0, 3'b0);
      chk("none_no_write", {63'd0, ifc.wr_ena}, 64'd0);

      // Back-to-back ALU/PC4 retires, one write per cycle.
      send(5'd2, WB_ALU, 32'h00000011, 32'h0, 3'b0);
      send(5'd3, WB_ALU, 32'h00000022, 32'h0, 3'b0);
      send(5'd4, WB_PC4, 32'h0, 32'h00001000, 3'b0);
      send(5'd31, WB_ALU, 32'hFFFFFFFF, 32'h0, 3'b0);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      do_load(5'd10, F3_LB, 2'd3, 32'h80FF1234, 32'hFFFFFF80, 3);
      do_load(5'd11, F3_LBU, 2'd3, 32'h80FF1234, 32'h00000080, 1);
      do_load(5'd12, F3_LHU, 2'd2, 32'h80FF1234, 32'h000080FF, 2);
      do_load(5'd13, F3_LH, 2'd2, 32'h80FF1234, 32'hFFFF80FF, 0);
      do_load(5'd14, F3_LH, 2'd0, 32'h80FF1234, 32'h00001234, 1);
      do_load(5'd15, F3_LB, 2'd1, 32'h80FF1234, 32'h00000012, 0);
      do_load(5'd16, F3_LW, 2'd0, 32'hCAFEF00D, 32'hCAFEF00D, 2);
      do_load(5'd0, F3_LW, 2'd0, 32'h11111111, 32'h0, 2);

      // Stray response in IDLE must not write.
      ifc.mem_rvalid = 1'b1;
      ifc.mem_rdata  = 32'hABCDABCD;
      tick();
      ifc.mem_rvalid = 1'b0;
      chk("stray_no_write", {63'd0, ifc.wr_ena}, 64'd0);

      bad_load(F3_LW, 2'd2);
      bad_load(3'b011, 2'd0);
      bad_load(F3_LHU, 2'd1);

      // Reset while a load is outstanding drops it.
      send(5'd20, WB_LOAD, 32'h400, 32'h0, F3_LW);
      chk("pre_rst_pend", {63'd0, ifc.pending_valid}, 64'd1);
      rst = 1'b1;
      #2;
      chk("mid_rst_pend", {63'd0, ifc.pending_valid}, 64'd0);
      chk("mid_rst_ready", {63'd0, ifc.in_ready}, 64'd1);
      rst = 1'b0;
      ifc.mem_rvalid = 1'b1;
      ifc.mem_rdata  = 32'h77777777;
      tick();
      ifc.mem_rvalid = 1'b0;
      chk("post_rst_no_write", {63'd0, ifc.wr_ena}, 64'd0);
      chk("post_rst_ready", {63'd0, ifc.in_ready}, 64'd1);
      tick();

`ifdef WB_INSTRET_EN
      rst = 1'b1;
      #2;
      chk("instret_rst", instret, 64'd0);
      rst = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) send(5'(i + 1), WB_ALU, 32'(i), 32'h0, 3'b0);
      do_load(5'd9, F3_LW, 2'd0, 32'h0BADF00D, 32'h0BADF00D, 1);
      bad_load(F3_LW, 2'd1);
      chk("instret", instret, 64'd5);
`endif

      chk("sb_final", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage directly upstream of the 32x32 register file; drives its write channel (wr_ena/wr_addr/wr_data).
- Accepts retiring instructions via valid/ready, selects the writeback source (ALU result, PC+4, or load data), and waits multi-cycle for memory load responses.
- Performs RV32I load byte/half extraction and sign/zero extension.
- Exposes the in-flight load destination for upstream hazard/stall logic.

Parameters:
- XLEN, 32, data width of results and register-file write data.
- NREG_BITS, 5, register address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  retiring instruction present.
- in_ready  output  1  unit can accept; high only in IDLE.
- in_rd  input  NREG_BITS  destination register.
- in_src  input  2  writeback source: wb_src_t NONE=0, ALU=1, PC4=2, LOAD=3.
- in_alu_result  input  XLEN  ALU result; for LOAD, the effective address (bits [1:0] used).
- in_pc  input  XLEN  instruction PC.
- in_funct3  input  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- mem_rvalid  input  1  load response valid (single-cycle pulse).
- mem_rdata  input  XLEN  aligned word from data memory.
- wr_ena  output  1  register-file write enable, registered.
- wr_addr  output  NREG_BITS  register-file write address, registered.
- wr_data  output  XLEN  register-file write data, registered.
- pending_valid  output  1  load in flight (state WAIT_MEM).
- pending_rd  output  NREG_BITS  destination of in-flight load.
- err  output  1  one-cycle pulse on misaligned or illegal load.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - wr_ena=0, wr_addr=0, wr_data=0.
  - pending_valid=0, pending_rd=0, err=0.
  - in_ready=1 once rst deasserts.
- Accept: in_valid && in_ready at a rising edge.
- States:
  - IDLE: in_ready=1.
    - Accept with src ALU: next cycle wr_ena=1 (if rd!=0), wr_data=in_alu_result. Latency 1.
    - Accept with src PC4: same timing, wr_data=in_pc+4, modulo 2^XLEN (wraps 0xFFFFFFFC -> 0).
    - Accept with src NONE: no write.
    - Accept with src LOAD, legal and aligned: latch rd/funct3/addr[1:0], go to WAIT_MEM.
    - Accept with src LOAD, illegal funct3 or misaligned: err=1 next cycle, no write, stay IDLE. Misaligned means LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
  - WAIT_MEM: in_ready=0, pending_valid=1, pending_rd=latched rd.
    - On mem_rvalid: next cycle wr_ena=1 (if rd!=0), wr_data=extended data; state returns to IDLE on the same edge.
    - Waits indefinitely until mem_rvalid.
- Load extraction:
  - Byte = mem_rdata[8*addr[1:0] +: 8].
  - Half = mem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- rd=0: wr_ena stays 0 for every source; state sequencing is unchanged (a load to x0 still waits for mem_rvalid).
- wr_ena and err are single-cycle pulses, deasserting the cycle after assertion unless a new write or error occurs.
- wr_addr/wr_data hold their last values when wr_ena=0.
- mem_rvalid while in IDLE is ignored (stray or late response).
- Reset during WAIT_MEM: drops the pending load, returns to IDLE; a subsequent mem_rvalid is ignored.
- Back-to-back ALU accepts: one write per cycle, continuous throughput.

Optional Feature:
- Macro WB_INSTRET_EN.
- Defined: adds output instret[63:0], reset to 0, incremented by 1 on the cycle each instruction completes.
  - Completion = non-load accept, or mem_rvalid in WAIT_MEM.
  - Error accepts do not count; counter wraps at 2^64.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package wb_pkg:
  - typedef enum logic [1:0] wb_src_t {WB_NONE, WB_ALU, WB_PC4, WB_LOAD}.
  - Load funct3 constants F3_LB/F3_LH/F3_LW/F3_LBU/F3_LHU.
  - typedef enum wb_state_t {S_IDLE, S_WAIT_MEM}.
- One combinational sub-module load_extender (funct3, addr_lsb, rdata -> data, misaligned, illegal), reused later by the store/load path.

Test Plan:
- Reset then ALU rd=5, result 0xDEADBEEF -> next cycle wr_ena=1, wr_addr=5, wr_data=0xDEADBEEF; following cycle wr_ena=0.
- PC4 rd=1, pc=0xFFFFFFFC -> wr_data=0x00000000; ALU rd=0 -> wr_ena stays 0.
- LB rd=10, addr lsb=3, mem_rdata=0x80FF1234 after 3 wait cycles:
  - in_ready=0 and pending_valid=1 with pending_rd=10 while waiting.
  - wr_data=0xFFFFFF80 one cycle after mem_rvalid.
  - LBU same data -> 0x00000080; LHU addr lsb=2 -> 0x000080FF.
- LW addr lsb=2 -> err pulse, no write, in_ready stays 1; funct3=011 -> err.
- Assert rst during WAIT_MEM, then mem_rvalid -> no wr_ena, state IDLE, in_ready=1.
- WB_INSTRET_EN: 4 ALU + 1 load + 1 misaligned load -> instret=5.
